shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit register, built from a bank of our D flip-flops, among N_REQ requesters.
- Each requester presents a request and a data word. The arbiter grants exactly one requester per transaction and loads that requester's word into the shared register.
- The arbiter then publishes the word, tagged with the owner index, for a fixed hold window.
- It sits between the request sources and any logic that consumes the shared register.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width in bits
- HOLD_CYCLES, 2, cycles q_valid stays high after each load (1..15)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- req  input  N_REQ  request per requester, level
- d_in  input  N_REQ*WIDTH  data per requester; requester i drives d_in[i*WIDTH +: WIDTH]
- gnt  output  N_REQ  one-hot grant, registered
- q  output  WIDTH  shared register contents
- q_valid  output  1  high during the hold window after a load
- owner  output  clog2(N_REQ)  index of the requester whose word is in q
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rstn=0, asynchronous, takes effect immediately regardless of clk):
  - state=IDLE
  - gnt=0, q=0, q_valid=0, owner=0, busy=0
  - rr pointer=0, hold counter=0
- Release is synchronous in effect: the first state change happens on the first rising edge with rstn=1.
- Reset asserted mid-transaction aborts it. No load occurs, and the pointer returns to 0.
- FSM states: IDLE, GRANT, HOLD.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, select the winner w by searching req from index ptr upward, wrapping modulo N_REQ; the first set bit wins.
  - Register sel=w and go to GRANT.
  - gnt is set to one-hot(w) on the same edge.
- GRANT (exactly 1 cycle):
  - gnt=one-hot(sel).
  - On the exiting edge:
    - q <= d_in slice sel
    - owner <= sel
    - q_valid <= 1
    - gnt <= 0
    - ptr <= (sel+1) mod N_REQ
    - hold counter <= HOLD_CYCLES-1
    - go to HOLD
- HOLD:
  - q_valid=1 and no new arbitration.
  - The counter decrements each cycle.
  - On the edge where counter==0: q_valid <= 0, go to IDLE.
- q and owner retain their value after the hold window until the next load.
- Latency: req sampled high in IDLE at edge E0 gives gnt high in cycle E0..E1, q updated at E1, and q_valid high for exactly HOLD_CYCLES cycles.
- Minimum spacing between grants is HOLD_CYCLES+2 cycles.
- Requester contract:
  - Hold req and its data slice stable until gnt[i] is seen high.
  - Deassert req in the cycle after gnt, or keep it high to re-request.
  - A requester that keeps req high is eligible again but is not favoured, because the pointer has moved past it.
- Arbitration boundaries:
  - Only req at the IDLE decision edge matters.
  - A requester that drops req before that edge is not granted.
  - A req change during GRANT or HOLD does not affect the current transaction.
  - Simultaneous requests: exactly one grant, determined by the pointer. gnt is never more than one-hot.
  - Pointer wrap: a grant to N_REQ-1 sets ptr to 0.
  - A single persistent requester is granted every HOLD_CYCLES+2 cycles.
- busy=1 in GRANT and HOLD.

Test Plan:
- Reset: hold rstn=0 with req=4'b1111 and random d_in → gnt=0, q=0, q_valid=0, owner=0, busy=0. Then deassert rstn → first gnt=4'b0001.
- Single request: req=4'b0100, d_in slice2=8'hA5 → gnt=4'b0100 for 1 cycle. Next cycle q=8'hA5, owner=2, and q_valid high for exactly 2 cycles, then low with q still 8'hA5.
- Round-robin fairness: req=4'b1111 held, slices 8'h10/8'h21/8'h32/8'h43 → grant order 0,1,2,3,0, each grant 4 cycles apart, with q matching the granted slice.
- Pointer wrap and skip: after a grant to 3, set req=4'b0110 → next grant is 1, then 2. Req 0 is never granted.
- Request changes: during HOLD, drop req 1 and raise req 3 with ptr=1 → next grant is 3. A req pulse that falls before the IDLE decision edge → no grant.
- Async reset mid-GRANT: drop rstn for 3 ns between edges while gnt=4'b0010 → gnt, q_valid, and busy go to 0 immediately, and q keeps its reset value 0 with no load of slice1.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter that time-shares one WIDTH-bit register among N_REQ
//   requesters. A winner is picked in IDLE, granted for one cycle, and its
//   data word is loaded into the shared register. The word is then published
//   with q_valid for HOLD_CYCLES cycles before the next arbitration.
//
// Ports:
//   clk      system clock, rising edge
//   rstn     asynchronous active-low reset
//   req      per-requester request level
//   d_in     per-requester data; requester i drives d_in[i*WIDTH +: WIDTH]
//   gnt      registered one-hot grant (high during GRANT)
//   q        shared register contents
//   q_valid  high during the hold window after a load
//   owner    index of the requester whose word is in q
//   busy     high whenever the FSM is not in IDLE
module shared_reg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   d_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic             busy_q, busy_d;

  // Per-requester view of the flat data bus.
  logic [WIDTH-1:0] slice [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign slice[gi] = d_in[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: scan req starting at ptr, wrapping modulo N_REQ.
  // idx carries one extra bit so the wrap works for non-power-of-two N_REQ.
  logic [PW-1:0] win;
  logic          win_found;
  logic [PW:0]   idx;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) begin
        idx = idx - (PW+1)'(N_REQ);
      end
      if (!win_found && req[idx[PW-1:0]]) begin
        win       = idx[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    owner_d   = owner_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          sel_d        = win;
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        // The load happens on the edge leaving GRANT, so the data slice is
        // sampled one cycle after the arbitration decision.
        q_d       = slice[sel_q];
        owner_d   = sel_q;
        q_valid_d = 1'b1;
        gnt_d     = '0;
        ptr_d     = (sel_q == PW'(N_REQ-1)) ? '0 : sel_q + 1'b1;
        cnt_d     = 4'(HOLD_CYCLES-1);
        state_d   = HOLD;
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          q_valid_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        gnt_d     = '0;
        q_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Testbench for shared_reg_arbiter (N_REQ=4, WIDTH=8, HOLD_CYCLES=2).
// A cycle-by-cycle vector table drives req/d_in and lists the outputs
// expected after each rising edge; hand-written sequences cover reset,
// a short request pulse and an asynchronous reset during GRANT.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] d_in;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  shared_reg_arbiter #(
    .N_REQ      (4),
    .WIDTH      (8),
    .HOLD_CYCLES(2)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .d_in   (d_in),
    .gnt    (gnt),
    .q      (q),
    .q_valid(q_valid),
    .owner  (owner),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        qv;
    logic [1:0]  own;
    logic        busy;
  } vec_t;

  vec_t vecs [64];
  int   n_vec = 0;

  localparam logic [31:0] D1 = 32'h4332_2110;
  localparam logic [31:0] DA = 32'h00A5_0000;

  task automatic add(input logic [3:0] r, input logic [31:0] dn,
                     input logic [3:0] g, input logic [7:0] qq,
                     input logic qv, input logic [1:0] own, input logic b);
    vecs[n_vec].req  = r;
    vecs[n_vec].din  = dn;
    vecs[n_vec].gnt  = g;
    vecs[n_vec].q    = qq;
    vecs[n_vec].qv   = qv;
    vecs[n_vec].own  = own;
    vecs[n_vec].busy = b;
    n_vec++;
  endtask

  // Compares {gnt, q, q_valid, owner, busy} against the expected record.
  task automatic chk(input string name, input logic [3:0] g, input logic [7:0] qq,
                     input logic qv, input logic [1:0] own, input logic b);
    logic [15:0] act;
    logic [15:0] exp;
    act = {gnt, q, q_valid, owner, busy};
    exp = {g, qq, qv, own, b};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got gnt=%b q=%h qv=%b owner=%0d busy=%b, expected gnt=%b q=%h qv=%b owner=%0d busy=%b",
               name, gnt, q, q_valid, owner, busy, g, qq, qv, own, b);
    end else begin
      $display("ok   %s: gnt=%b q=%h qv=%b owner=%0d busy=%b", name, gnt, q, q_valid, owner, busy);
    end
  endtask

  initial begin
    // Fairness: all four requesting, grants 0,1,2,3,0 four cycles apart.
    add(4'b1111, D1, 4'b0001, 8'h00, 0, 0, 1);
    add(4'b1111, D1, 4'b0000, 8'h10, 1, 0, 1);
    add(4'b1111, D1, 4'b0000, 8'h10, 1, 0, 1);
    add(4'b1111, D1, 4'b0000, 8'h10, 0, 0, 0);
    add(4'b1111, D1, 4'b0010, 8'h10, 0, 0, 1);
    add(4'b1111, D1, 4'b0000, 8'h21, 1, 1, 1);
    add(4'b1111, D1, 4'b0000, 8'h21, 1, 1, 1);
    add(4'b1111, D1, 4'b0000, 8'h21, 0, 1, 0);
    add(4'b1111, D1, 4'b0100, 8'h21, 0, 1, 1);
    add(4'b1111, D1, 4'b0000, 8'h32, 1, 2, 1);
    add(4'b1111, D1, 4'b0000, 8'h32, 1, 2, 1);
    add(4'b1111, D1, 4'b0000, 8'h32, 0, 2, 0);
    add(4'b1111, D1, 4'b1000, 8'h32, 0, 2, 1);
    add(4'b1111, D1, 4'b0000, 8'h43, 1, 3, 1);
    add(4'b1111, D1, 4'b0000, 8'h43, 1, 3, 1);
    add(4'b1111, D1, 4'b0000, 8'h43, 0, 3, 0);
    add(4'b1111, D1, 4'b0001, 8'h43, 0, 3, 1);
    add(4'b1111, D1, 4'b0000, 8'h10, 1, 0, 1);
    add(4'b0000, D1, 4'b0000, 8'h10, 1, 0, 1);
    add(4'b0000, D1, 4'b0000, 8'h10, 0, 0, 0);
    // Grant 3 (pointer wraps to 0), then req=0110: grants 1 then 2.
    add(4'b1000, D1, 4'b1000, 8'h10, 0, 0, 1);
    add(4'b0110, D1, 4'b0000, 8'h43, 1, 3, 1);
    add(4'b0110, D1, 4'b0000, 8'h43, 1, 3, 1);
    add(4'b0110, D1, 4'b0000, 8'h43, 0, 3, 0);
    add(4'b0110, D1, 4'b0010, 8'h43, 0, 3, 1);
    add(4'b0110, D1, 4'b0000, 8'h21, 1, 1, 1);
    add(4'b0110, D1, 4'b0000, 8'h21, 1, 1, 1);
    add(4'b0110, D1, 4'b0000, 8'h21, 0, 1, 0);
    add(4'b0110, D1, 4'b0100, 8'h21, 0, 1, 1);
    add(4'b0000, D1, 4'b0000, 8'h32, 1, 2, 1);
    add(4'b0000, D1, 4'b0000, 8'h32, 1, 2, 1);
    add(4'b0000, D1, 4'b0000, 8'h32, 0, 2, 0);
    // ptr=3, req=0011 -> grant 0 (wrap). In HOLD drop req1, raise req3:
    // with ptr=1 the next grant is 3, ahead of the still-pending req0.
    add(4'b0011, D1, 4'b0001, 8'h32, 0, 2, 1);
    add(4'b0011, D1, 4'b0000, 8'h10, 1, 0, 1);
    add(4'b1001, D1, 4'b0000, 8'h10, 1, 0, 1);
    add(4'b1001, D1, 4'b0000, 8'h10, 0, 0, 0);
    add(4'b1001, D1, 4'b1000, 8'h10, 0, 0, 1);
    add(4'b0000, D1, 4'b0000, 8'h43, 1, 3, 1);
    add(4'b0000, D1, 4'b0000, 8'h43, 1, 3, 1);
    add(4'b0000, D1, 4'b0000, 8'h43, 0, 3, 0);
    // Single request from 2 with A5; q and owner held after the window.
    add(4'b0100, DA, 4'b0100, 8'h43, 0, 3, 1);
    add(4'b0000, DA, 4'b0000, 8'hA5, 1, 2, 1);
    add(4'b0000, DA, 4'b0000, 8'hA5, 1, 2, 1);
    add(4'b0000, DA, 4'b0000, 8'hA5, 0, 2, 0);
    add(4'b0000, DA, 4'b0000, 8'hA5, 0, 2, 0);

    // Reset held with all requesting and random data.
    rstn = 1'b0;
    req  = 4'b1111;
    d_in = $urandom;
    #1;
    chk("reset_t0", 4'b0000, 8'h00, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_held", 4'b0000, 8'h00, 0, 0, 0);

    d_in = D1;
    rstn = 1'b1;
    for (int i = 0; i < n_vec; i++) begin
      req  = vecs[i].req;
      d_in = vecs[i].din;
      @(posedge clk);
      #2;
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].qv,
          vecs[i].own, vecs[i].busy);
    end

    // Short pulse on req2 that falls before the decision edge: no grant.
    req = 4'b0100;
    #4;
    req = 4'b0000;
    @(posedge clk);
    #2;
    chk("pulse_e1", 4'b0000, 8'hA5, 0, 2, 0);
    @(posedge clk);
    #2;
    chk("pulse_e2", 4'b0000, 8'hA5, 0, 2, 0);

    // ptr=3: req1 alone is granted, then reset lands during GRANT.
    d_in = D1;
    req  = 4'b0010;
    @(posedge clk);
    #2;
    chk("pre_rst_gnt", 4'b0010, 8'hA5, 0, 2, 1);
    rstn = 1'b0;
    #1;
    chk("async_rst", 4'b0000, 8'h00, 0, 0, 0);
    req = 4'b0000;
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_e1", 4'b0000, 8'h00, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("post_rst_e2", 4'b0000, 8'h00, 0, 0, 0);
    // Pointer is back at 0: full request set grants requester 0.
    req = 4'b1111;
    @(posedge clk);
    #2;
    chk("ptr_reset_gnt", 4'b0001, 8'h00, 0, 0, 1);
    req = 4'b0000;
    @(posedge clk);
    #2;
    chk("ptr_reset_load", 4'b0000, 8'h10, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
